// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: segment bit positions, all-dark value, hex glyph table.
package ssd_pkg;

  // seg = {a,b,c,d,e,f,g,dp}, active low
  localparam int SEG_A_BIT  = 7;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  localparam logic [7:0] SEG_DARK = 8'hFF;

  // Active-low {a..g} pattern for a hex code (0-9, A, b, C, d, E, F)
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ssd_glyph_rom.sv
// Combinational hex-to-segment decode with decimal point (active-low outputs).
module ssd_glyph_rom
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  // Glyph bits from the shared table, dp lit when requested
  always_comb begin
    seg = SEG_DARK;
    seg[SEG_A_BIT:SEG_G_BIT] = glyph(code);
    seg[SEG_DP_BIT] = ~dp;
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with shadowed display data applied at frame boundaries.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lzs_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              seg,
  output logic                    load_ack,
  output logic                    frame_tick
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] slot_cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic          pending;

  logic [4*NUM_DIGITS-1:0] shd_digits, act_digits;
  logic [NUM_DIGITS-1:0]   shd_dp, shd_blank, shd_blink;
  logic [NUM_DIGITS-1:0]   act_dp, act_blank, act_blink;
  logic                    shd_lzs, act_lzs;

  logic slot_last, idx_last, frame_end, blink_last;

  assign slot_last  = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign idx_last   = (idx == IW'(NUM_DIGITS - 1));
  assign frame_end  = slot_last & idx_last;
  assign blink_last = (blink_cnt == BW'(BLINK_DIV - 1));
  assign frame_tick = frame_end;

  // Slot counter and digit index scan
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_cnt <= '0;
      idx      <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= idx_last ? '0 : idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Free-running blink phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_last) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Shadow capture on load; shadow moves to active only at a frame boundary.
  // A load in the boundary cycle itself is held for the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shd_digits <= '0;
      shd_dp     <= '0;
      shd_blank  <= '1;
      shd_blink  <= '0;
      shd_lzs    <= 1'b0;
      act_digits <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      act_blink  <= '0;
      act_lzs    <= 1'b0;
      pending    <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        act_digits <= shd_digits;
        act_dp     <= shd_dp;
        act_blank  <= shd_blank;
        act_blink  <= shd_blink;
        act_lzs    <= shd_lzs;
      end
      if (load) begin
        shd_digits <= digits;
        shd_dp     <= dp_mask;
        shd_blank  <= blank_mask;
        shd_blink  <= blink_mask;
        shd_lzs    <= lzs_en;
      end
      pending  <= load | (pending & ~frame_end);
      load_ack <= frame_end & pending;
    end
  end

  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;

  // Digits at or above a position that are all zero form the suppressible leading run
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run     = zero_run & (act_digits[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
  end

  logic [3:0] cur_code;
  logic [7:0] glyph_seg;
  logic       digit_on, in_dead;

  assign cur_code = act_digits[{idx, 2'b00} +: 4];
  assign in_dead  = (slot_cnt < SW'(DEAD_CYCLES));
  assign digit_on = ~act_blank[idx] & ~(phase & act_blink[idx]) & ~(act_lzs & lead_zero[idx]);

  ssd_glyph_rom u_rom (
    .code (cur_code),
    .dp   (act_dp[idx]),
    .seg  (glyph_seg)
  );

  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            seg_d;

  // Next anode/segment drive: dark in blanking cycles or when the digit is disabled
  always_comb begin
    an_d  = '1;
    seg_d = SEG_DARK;
    if (!in_dead && digit_on) begin
      an_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
      seg_d = glyph_seg;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_DARK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver against a cycle-count based reference model.
module tb_ssd_scan_driver;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int DEAD  = 1;
  localparam int BD    = 64;
  localparam int FRAME = N * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in_digits = '0;
  logic [3:0]  in_dp = '0, in_blank = '0, in_blink = '0;
  logic        in_lzs = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        load_ack, frame_tick;

  ssd_scan_driver #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(RD),
    .DEAD_CYCLES(DEAD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .digits    (in_digits),
    .dp_mask   (in_dp),
    .blank_mask(in_blank),
    .blink_mask(in_blink),
    .lzs_en    (in_lzs),
    .an        (an),
    .seg       (seg),
    .load_ack  (load_ack),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int acks  = 0;

  // Reference model: cycle number since reset release plus shadow/active contents
  int          k;
  logic [15:0] a_dig, s_dig;
  logic [3:0]  a_dp, a_bl, a_bk, s_dp, s_bl, s_bk;
  logic        a_lz, s_lz, pend;
  string       lit_tab [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t k=%0d)", tag, obs, exp, $time, k);
    end
  endtask

  // Active-low {a..g} from the list of lit segment letters
  function automatic logic [6:0] lit_to_glyph(input string s);
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[6 - (s[i] - 8'd97)] = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    a_dig = '0; s_dig = '0;
    a_dp = '0; s_dp = '0;
    a_bl = '1; s_bl = '1;
    a_bk = '0; s_bk = '0;
    a_lz = 1'b0; s_lz = 1'b0;
    pend = 1'b0;
    k = 0;
  endtask

  // What the display should show for cycle c (visible one clock later)
  task automatic disp(input int c, output logic [3:0] e_an, output logic [7:0] e_seg, output bit sc);
    int slot, ix, ph, msd;
    logic [3:0] d;
    bit on;
    slot = c % RD;
    ix   = (c / RD) % N;
    ph   = (c / BD) % 2;
    e_an = 4'hF; e_seg = 8'hFF; sc = 1'b1;
    if (slot >= DEAD) begin
      msd = 0;
      for (int j = 0; j < N; j++) if (((a_dig >> (4*j)) & 16'hF) != 0) msd = j;
      on = !a_bl[ix] && !(ph == 1 && a_bk[ix]) && !(a_lz && ix > msd);
      if (on) begin
        d = 4'((a_dig >> (4*ix)) & 16'hF);
        e_an  = ~(4'b0001 << ix);
        e_seg = {lit_to_glyph(lit_tab[d]), ~a_dp[ix]};
      end else begin
        sc = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    logic [3:0] e_an;
    logic [7:0] e_seg;
    bit         sc;
    logic       e_ack;
    disp(k, e_an, e_seg, sc);
    e_ack = ((k % FRAME) == FRAME - 1) && pend;
    @(posedge clk);
    if (e_ack) begin
      a_dig = s_dig; a_dp = s_dp; a_bl = s_bl; a_bk = s_bk; a_lz = s_lz;
      pend = 1'b0;
    end
    if (load) begin
      s_dig = in_digits; s_dp = in_dp; s_bl = in_blank; s_bk = in_blink; s_lz = in_lzs;
      pend = 1'b1;
    end
    k++;
    #1;
    load = 1'b0;
    chk("an", 32'(an), 32'(e_an));
    if (sc) chk("seg", 32'(seg), 32'(e_seg));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
    chk("frame_tick", 32'(frame_tick), 32'((k % FRAME) == FRAME - 1));
    if (load_ack) acks++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                         input logic [3:0] bk, input logic lz);
    in_digits = d; in_dp = dp; in_blank = bl; in_blink = bk; in_lzs = lz;
    load = 1'b1;
    cycle();
  endtask

  // Asynchronous reset assertion mid-cycle, held for a few clocks, then released
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_hold_an", 32'(an), 32'hF);
      chk("rst_hold_seg", 32'(seg), 32'hFF);
    end
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    lit_tab = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    model_reset();
    #12;
    do_reset();

    // No load: dark display, frame_tick every frame
    run(256);

    // 12AF, masks clear
    do_load(16'h12AF, 4'h0, 4'h0, 4'h0, 1'b0);
    run(80);

    // Leading-zero suppression on, then off
    do_load(16'h0005, 4'h0, 4'h0, 4'h0, 1'b1);
    run(70);
    do_load(16'h0005, 4'h0, 4'h0, 4'h0, 1'b0);
    run(70);

    // Blink on digit 1
    do_load(16'h8888, 4'h0, 4'h0, 4'b0010, 1'b0);
    run(300);

    // Two loads before a boundary, then a third exactly in the boundary cycle
    while ((k % FRAME) != 4) cycle();
    acks = 0;
    do_load(16'h1111, 4'h1, 4'h0, 4'h0, 1'b0);
    run(5);
    do_load(16'h2222, 4'h2, 4'h0, 4'h0, 1'b0);
    while ((k % FRAME) != FRAME - 1) cycle();
    do_load(16'h3333, 4'h4, 4'h0, 4'h0, 1'b0);
    run(2 * FRAME);
    chk("ack_count_overlap", 32'(acks), 32'd2);

    // Randomized loads at random spacing
    for (int r = 0; r < 25; r++) begin
      logic [15:0] msk;
      case ($urandom_range(0, 3))
        0: msk = 16'hFFFF;
        1: msk = 16'h0FFF;
        2: msk = 16'h00FF;
        default: msk = 16'h000F;
      endcase
      do_load(16'($urandom) & msk, 4'($urandom), 4'($urandom) & 4'($urandom),
              4'($urandom), 1'($urandom));
      run($urandom_range(1, 60));
    end

    // Reset mid-slot with a load pending
    while ((k % FRAME) != 10) cycle();
    do_load(16'h4321, 4'hF, 4'h0, 4'h0, 1'b0);
    run(2);
    do_reset();
    acks = 0;
    run(100);
    chk("ack_count_after_reset", 32'(acks), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
